load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request offered.
- req_ready  out  1  unit can accept a request.
- req_kind  in  load_kind_t  decoded load kind (lk_lb, lk_lh, lk_lw, lk_lbu, lk_lhu, lk_invalid).
- req_addr  in  32  effective byte address.
- req_rd  in  5  destination register tag.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned read address.
- mem_gnt  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- mem_rdata  in  32  read word, little-endian.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  32  aligned, extended load result.
- resp_rd  out  5  echo of req_rd.
- resp_err  out  lu_err_t  lu_ok, lu_misaligned or lu_illegal.

Function
REQ-002 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-003 req_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted when req_valid and req_ready are both 1; kind, addr and rd SHALL be latched on that edge.
REQ-005 On acceptance, lk_invalid SHALL go to RESP with resp_err=lu_illegal and resp_data=0, and SHALL issue no mem_req.
REQ-006 On acceptance, a misaligned access SHALL go to RESP with resp_err=lu_misaligned and resp_data=0, and SHALL issue no mem_req.
- lh/lhu is misaligned when addr[0]=1.
- lw is misaligned when addr[1:0]!=0.
- lb/lbu is never misaligned.
REQ-007 Any other accepted request SHALL go to REQ.
REQ-008 In REQ, mem_req SHALL be 1 and mem_addr SHALL be {addr[31:2],2'b00}; both SHALL be held until mem_gnt, then the FSM SHALL go to WAIT.
REQ-009 mem_rvalid SHALL be ignored outside WAIT.
REQ-010 In WAIT, on mem_rvalid the formatted data SHALL be registered into resp_data with resp_err=lu_ok, and the FSM SHALL go to RESP.
REQ-011 Data formatting (byte lane selected by the latched addr) SHALL be:
- lb: byte addr[1:0], sign-extended.
- lbu: byte addr[1:0], zero-extended.
- lh: halfword addr[1], sign-extended.
- lhu: halfword addr[1], zero-extended.
- lw: full word.
REQ-012 In RESP, resp_valid SHALL be 1, with resp_data, resp_rd and resp_err held stable until resp_ready; on resp_valid and resp_ready the FSM SHALL return to IDLE.
REQ-013 A new request SHALL NOT be accepted in the same cycle a response retires; minimum occupancy is one cycle in IDLE.
REQ-014 Minimum latency with an immediate gnt, rvalid on the next cycle and an always-ready consumer SHALL be: accept at cycle 0, mem_req at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
REQ-015 The unit SHALL have at most one outstanding memory read.

Reset
REQ-016 While rst=1, asynchronously, the FSM SHALL enter IDLE and the outputs SHALL be:
- req_ready=1 (once in IDLE).
- mem_req=0, mem_addr=0.
- resp_valid=0, resp_data=0, resp_rd=0, resp_err=lu_ok.
REQ-017 Reset asserted during REQ or WAIT SHALL abandon the access; a later mem_rvalid SHALL be ignored because the FSM is in IDLE.

Structure
REQ-018 Package instr_type SHALL hold load_kind_t, the new enum lu_err_t and the FSM state enum lu_state_t.
REQ-019 The formatting of REQ-011 SHALL be a combinational sub-module load_align (inputs: kind, addr[1:0], word; output: 32-bit data), reusable by a future store path's tests.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- lb, addr 0x1003, rdata 0x80FF_1234 -> resp_data 0xFFFF_FF80, mem_addr 0x1000, resp_err lu_ok.
- lhu, addr 0x2002, rdata 0xBEEF_0001 -> resp_data 0x0000_BEEF; lh at the same address -> 0xFFFF_BEEF.
- lw, addr 0x3006 -> resp_err lu_misaligned, resp_data 0, mem_req never asserted; lk_invalid -> lu_illegal, no mem_req.
- mem_gnt withheld 3 cycles -> mem_req and mem_addr stable all 3 cycles; resp_ready withheld 2 cycles -> resp_* stable, req_ready 0 throughout.
- rst pulsed during WAIT, then mem_rvalid arrives -> no resp_valid, unit in IDLE with req_ready=1.
- Back-to-back lw 0x0, then lw 0x4, with immediate gnt/rvalid -> two responses in order, with correct resp_rd echoes.

Source files
------------

// File: rtl/instr_type.sv
// Shared load-path types: decoded load kind, load-unit error code and FSM state.
package instr_type;

  typedef enum logic [2:0] {
    lk_lb      = 3'd0,
    lk_lh      = 3'd1,
    lk_lw      = 3'd2,
    lk_lbu     = 3'd3,
    lk_lhu     = 3'd4,
    lk_invalid = 3'd5
  } load_kind_t;

  typedef enum logic [1:0] {
    lu_ok         = 2'd0,
    lu_misaligned = 2'd1,
    lu_illegal    = 2'd2
  } lu_err_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lu_state_t;

  // Error classification known at acceptance; lu_ok means a memory read is needed.
  function automatic lu_err_t accept_err(input load_kind_t kind, input logic [1:0] addr_lo);
    lu_err_t err;
    case (kind)
      lk_lb, lk_lbu: err = lu_ok;
      lk_lh, lk_lhu: err = addr_lo[0] ? lu_misaligned : lu_ok;
      lk_lw:         err = (addr_lo != 2'b00) ? lu_misaligned : lu_ok;
      default:       err = lu_illegal;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a little-endian read word and extends it.
module load_align
  import instr_type::*;
(
  input  load_kind_t  i_kind,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_addr)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    case (i_kind)
      lk_lb:   o_data = {{24{w_byte[7]}}, w_byte};
      lk_lbu:  o_data = {24'h0, w_byte};
      lk_lh:   o_data = {{16{w_half[15]}}, w_half};
      lk_lhu:  o_data = {16'h0, w_half};
      lk_lw:   o_data = i_word;
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: accepts a decoded load, issues one word read,
// formats the returned lane and holds the result until the consumer takes it.
module load_unit
  import instr_type::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  load_kind_t  req_kind,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output lu_err_t     resp_err
);

  lu_state_t   r_state;
  lu_state_t   w_state_next;
  load_kind_t  r_kind;
  logic [31:0] r_addr;
  logic [4:0]  r_rd;
  logic [31:0] r_resp_data;
  lu_err_t     r_resp_err;

  logic        w_accept;
  lu_err_t     w_accept_err;
  logic        w_rdata_take;
  logic [31:0] w_fmt_data;

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_accept_err = accept_err(req_kind, req_addr[1:0]);
  // Read data only counts while a read is actually outstanding.
  assign w_rdata_take = (r_state == WAIT) && mem_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = (w_accept_err == lu_ok) ? REQ : RESP;
        end
      end
      REQ:     if (mem_gnt)    w_state_next = WAIT;
      WAIT:    if (mem_rvalid) w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == IDLE);
    mem_req    = (r_state == REQ);
    mem_addr   = (r_state == REQ) ? {r_addr[31:2], 2'b00} : 32'h0;
    resp_valid = (r_state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind      <= lk_lb;
      r_addr      <= 32'h0;
      r_rd        <= 5'h0;
      r_resp_data <= 32'h0;
      r_resp_err  <= lu_ok;
    end else if (w_accept) begin
      r_kind      <= req_kind;
      r_addr      <= req_addr;
      r_rd        <= req_rd;
      r_resp_data <= 32'h0;
      r_resp_err  <= w_accept_err;
    end else if (w_rdata_take) begin
      r_resp_data <= w_fmt_data;
      r_resp_err  <= lu_ok;
    end
  end

  assign resp_data = r_resp_data;
  assign resp_rd   = r_rd;
  assign resp_err  = r_resp_err;

  load_align u_load_align (
    .i_kind (r_kind),
    .i_addr (r_addr[1:0]),
    .i_word (mem_rdata),
    .o_data (w_fmt_data)
  );

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed vector table, hand-written reset and
// back-to-back sequences, and randomized loads checked against an arithmetic model.
module tb_load_unit;
  import instr_type::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  load_kind_t  req_kind = lk_lb;
  logic [31:0] req_addr = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  lu_err_t     resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  load_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    load_kind_t  kind;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] word;
    int          gw;
    int          rw;
    logic [31:0] exp_data;
    lu_err_t     exp_err;
    logic [31:0] exp_maddr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic load_kind_t kind_of(input int unsigned i);
    case (i)
      0: return lk_lb;
      1: return lk_lh;
      2: return lk_lw;
      3: return lk_lbu;
      4: return lk_lhu;
      default: return lk_invalid;
    endcase
  endfunction

  // Reference model from the load rules, using shifts and modular arithmetic.
  function automatic void model(input load_kind_t k, input logic [31:0] a,
                                input logic [31:0] w, output logic [31:0] d,
                                output lu_err_t e);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    d = 0;
    e = lu_ok;
    case (k)
      lk_lb:  d = (b >= 128) ? b - 32'd256 : b;
      lk_lbu: d = b;
      lk_lh:  if (a % 2 != 0) e = lu_misaligned; else d = (h >= 32768) ? h - 32'd65536 : h;
      lk_lhu: if (a % 2 != 0) e = lu_misaligned; else d = h;
      lk_lw:  if (a % 4 != 0) e = lu_misaligned; else d = w;
      default: e = lu_illegal;
    endcase
  endfunction

  // Runs one load from a negedge; plays memory (gnt after gw cycles, rvalid next cycle)
  // and consumer (ready after rw cycles of resp_valid). Ends at a negedge.
  task automatic run_txn(input load_kind_t k, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] word, input int gw, input int rw,
                         output logic [31:0] o_data, output lu_err_t o_err,
                         output logic [4:0] o_rd, output logic [31:0] o_maddr,
                         output int o_nreq, output int o_lat, output bit o_unstable,
                         output bit o_busy_ready, output bit o_post_ok, output bit o_tmo);
    int  gcnt = 0;
    int  rcnt = 0;
    int  wcyc = 0;
    bit  rv_next = 0;
    bit  got = 0;
    bit  done = 0;
    o_data = '0; o_err = lu_ok; o_rd = '0; o_maddr = '0; o_nreq = 0; o_lat = 0;
    o_unstable = 0; o_busy_ready = 0; o_post_ok = 0; o_tmo = 0;
    while (!req_ready && wcyc < 20) begin
      @(negedge clk);
      wcyc++;
    end
    if (!req_ready) begin
      o_tmo = 1;
      return;
    end
    req_valid = 1; req_kind = k; req_addr = a; req_rd = rd;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      req_valid = 0;
      req_kind = kind_of($urandom_range(0, 5));
      req_addr = $urandom;
      req_rd = 5'($urandom);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom; resp_ready = 0;
      if (req_ready) o_busy_ready = 1;
      if (mem_req) begin
        if (o_nreq == 0) o_maddr = mem_addr;
        else if (mem_addr !== o_maddr) o_unstable = 1;
        o_nreq++;
        if (gcnt >= gw) begin
          mem_gnt = 1;
          rv_next = 1;
        end else begin
          gcnt++;
          mem_rvalid = 1;  // stray rvalid before the grant must be ignored
        end
      end else if (rv_next) begin
        mem_rvalid = 1;
        mem_rdata = word;
        rv_next = 0;
      end
      if (resp_valid) begin
        if (!got) begin
          got = 1; o_data = resp_data; o_err = resp_err; o_rd = resp_rd; o_lat = cyc;
        end else if (resp_data !== o_data || resp_err !== o_err || resp_rd !== o_rd) begin
          o_unstable = 1;
        end
        mem_rvalid = 1;  // stray rvalid while holding a response must be ignored
        if (rcnt >= rw) begin
          resp_ready = 1;
          done = 1;
        end else begin
          rcnt++;
        end
      end
    end
    @(negedge clk);
    resp_ready = 0; mem_rvalid = 0; mem_gnt = 0;
    if (!done) o_tmo = 1;
    o_post_ok = req_ready && !resp_valid;
  endtask

  task automatic check_txn(input string tag, input load_kind_t k, input logic [31:0] a,
                           input logic [4:0] rd, input logic [31:0] word, input int gw,
                           input int rw, input logic [31:0] exp_data, input lu_err_t exp_err,
                           input logic [31:0] exp_maddr);
    logic [31:0] d, ma;
    lu_err_t     e;
    logic [4:0]  r;
    int          nreq, lat;
    bit          unst, busy, post, tmo;
    bit          mem_path;
    run_txn(k, a, rd, word, gw, rw, d, e, r, ma, nreq, lat, unst, busy, post, tmo);
    mem_path = (exp_err == lu_ok);
    chk({tag, " timeout"}, 32'(tmo), 0);
    chk({tag, " resp_data"}, d, exp_data);
    chk({tag, " resp_err"}, 32'(e), 32'(exp_err));
    chk({tag, " resp_rd"}, 32'(r), 32'(rd));
    chk({tag, " mem_addr"}, ma, exp_maddr);
    chk({tag, " mem_req cycles"}, 32'(nreq), mem_path ? 32'(gw + 1) : 0);
    chk({tag, " latency"}, 32'(lat), mem_path ? 32'(gw + 3) : 1);
    chk({tag, " held stable"}, 32'(unst), 0);
    chk({tag, " req_ready while busy"}, 32'(busy), 0);
    chk({tag, " idle after retire"}, 32'(post), 1);
  endtask

  vec_t vecs[10];

  initial begin
    logic [31:0] md;
    lu_err_t     me;
    load_kind_t  k;
    logic [31:0] a, w;

    vecs[0] = '{lk_lb,      32'h1003, 5'd1,  32'h80FF1234, 0, 0, 32'hFFFFFF80, lu_ok,
                32'h1000};
    vecs[1] = '{lk_lhu,     32'h2002, 5'd2,  32'hBEEF0001, 0, 0, 32'h0000BEEF, lu_ok,
                32'h2000};
    vecs[2] = '{lk_lh,      32'h2002, 5'd3,  32'hBEEF0001, 0, 0, 32'hFFFFBEEF, lu_ok,
                32'h2000};
    vecs[3] = '{lk_lw,      32'h3006, 5'd4,  32'h12345678, 0, 0, 32'h0, lu_misaligned, 32'h0};
    vecs[4] = '{lk_invalid, 32'h0040, 5'd5,  32'h12345678, 0, 0, 32'h0, lu_illegal, 32'h0};
    vecs[5] = '{lk_lw,      32'h5000, 5'd6,  32'hDEADBEEF, 3, 2, 32'hDEADBEEF, lu_ok,
                32'h5000};
    vecs[6] = '{lk_lbu,     32'h6001, 5'd7,  32'h00009A00, 0, 1, 32'h0000009A, lu_ok,
                32'h6000};
    vecs[7] = '{lk_lh,      32'h7001, 5'd8,  32'hFFFFFFFF, 0, 0, 32'h0, lu_misaligned, 32'h0};
    vecs[8] = '{lk_lb,      32'h8002, 5'd9,  32'h007F0000, 1, 0, 32'h0000007F, lu_ok,
                32'h8000};
    vecs[9] = '{lk_lh,      32'h9000, 5'd31, 32'h00008001, 0, 0, 32'hFFFF8001, lu_ok,
                32'h9000};

    // Asynchronous reset: outputs must settle before any clock edge.
    #1 rst = 1;
    #2;
    chk("reset req_ready", 32'(req_ready), 1);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset resp_data", resp_data, 0);
    chk("reset resp_rd", 32'(resp_rd), 0);
    chk("reset resp_err", 32'(resp_err), 32'(lu_ok));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) begin
      check_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].rd, vecs[i].word,
                vecs[i].gw, vecs[i].rw, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_maddr);
    end

    // Reset while a read is outstanding; the late rvalid must be ignored.
    req_valid = 1; req_kind = lk_lw; req_addr = 32'h100; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 0;
    chk("rstwait mem_req", 32'(mem_req), 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rstwait in WAIT", 32'({mem_req, resp_valid, req_ready}), 0);
    rst = 1;
    #1;
    chk("rstwait async req_ready", 32'(req_ready), 1);
    chk("rstwait async mem_req", 32'(mem_req), 0);
    @(negedge clk);
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rstwait resp_valid c%0d", c), 32'(resp_valid), 0);
      chk($sformatf("rstwait req_ready c%0d", c), 32'(req_ready), 1);
      @(negedge clk);
    end

    // Back-to-back word loads with immediate grant/rvalid and ready consumer.
    check_txn("b2b0", lk_lw, 32'h0, 5'd10, 32'h11111111, 0, 0, 32'h11111111, lu_ok, 32'h0);
    check_txn("b2b1", lk_lw, 32'h4, 5'd11, 32'h22222222, 0, 0, 32'h22222222, lu_ok, 32'h4);

    for (int n = 0; n < 40; n++) begin
      k = kind_of($urandom_range(0, 5));
      a = $urandom;
      w = $urandom;
      model(k, a, w, md, me);
      check_txn($sformatf("rnd%0d", n), k, a, 5'($urandom), w, $urandom_range(0, 2),
                $urandom_range(0, 2), md, me, (me == lu_ok) ? {a[31:2], 2'b00} : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
